// File: rtl/div_const_pkg.sv
// Shared constants and FSM state type for the divide-by-5 engine.
package div_const_pkg;
    localparam int DIVISOR = 5;
    localparam int REM_W   = 3;
    localparam int CHUNK   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/div5_digit_step.sv
// One radix-4 digit of division by 5: v = 4*rem + d -> q = v/5, rem_next = v%5.
// Purely combinational, zero latency, no flow control.
module div5_digit_step
    import div_const_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic [1:0]       d,
    output logic [1:0]       q,
    output logic [REM_W-1:0] rem_next
);
    logic [4:0] w_v;

    assign w_v = {rem, d};

    // rem is always 0..4, so v stays within 0..19 and q never exceeds 3
    always_comb begin
        q        = 2'd0;
        rem_next = w_v[REM_W-1:0];
        if (w_v >= 5'd15) begin
            q        = 2'd3;
            rem_next = REM_W'(w_v - 5'd15);
        end else if (w_v >= 5'd10) begin
            q        = 2'd2;
            rem_next = REM_W'(w_v - 5'd10);
        end else if (w_v >= 5'd5) begin
            q        = 2'd1;
            rem_next = REM_W'(w_v - 5'd5);
        end
    end
endmodule

// File: rtl/div5_seq_iter.sv
// Iterative unsigned divide-by-5, MSB-first, CHUNK bits per cycle; result NITER edges after accept.
// Single division in flight: in_ready only in IDLE; DONE holds the result until out_ready.
module div5_seq_iter
    import div_const_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [REM_W-1:0] out_rem
);
    localparam int NITER = WIDTH / CHUNK;
    localparam int CW    = $clog2(NITER);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quot;
    logic [REM_W-1:0] r_rem;
    logic [WIDTH-1:0] r_out_quot;
    logic [REM_W-1:0] r_out_rem;

    logic [1:0]       w_q;
    logic [REM_W-1:0] w_rem_nxt;
    logic             w_last;

    div5_digit_step u_step (
        .rem      (r_rem),
        .d        (r_div[WIDTH-1 -: CHUNK]),
        .q        (w_q),
        .rem_next (w_rem_nxt)
    );

    assign w_last = (r_cnt == CW'(NITER - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_div      <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_out_quot <= '0;
            r_out_rem  <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_div  <= in_data;
                        r_quot <= '0;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_div  <= r_div << CHUNK;
                    r_quot <= {r_quot[WIDTH-CHUNK-1:0], w_q};
                    r_rem  <= w_rem_nxt;
                    // counter naturally wraps to 0 on the final iteration
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out_quot <= {r_quot[WIDTH-CHUNK-1:0], w_q};
                        r_out_rem  <= w_rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_quot = r_out_quot;
    assign out_rem  = r_out_rem;
endmodule
